// File: rtl/snake_segment_engine.sv
// Snake segment store with step/grow/wrap, sequential head-vs-body collision scan,
// and a 2-stage per-pixel head/body hit pipeline on the pixel clock.
module snake_segment_engine #(
    parameter int MAX_LEN  = 32,
    parameter int LEN_W    = $clog2(MAX_LEN + 1),
    parameter int POS_W    = 10,
    parameter int CNT_H_W  = 10,
    parameter int CNT_V_W  = 10,
    parameter int SQ       = 10,
    parameter int X_MAX    = 640,
    parameter int Y_MAX    = 480,
    parameter int INIT_LEN = 3,
    parameter int INIT_X   = 320,
    parameter int INIT_Y   = 240
) (
    input  logic               clk_25,
    input  logic               reset_game,
    input  logic               step,
    input  logic [1:0]         dir,
    input  logic               grow,
    input  logic [CNT_H_W-1:0] count_H,
    input  logic [CNT_V_W-1:0] count_V,
    output logic [LEN_W-1:0]   snake_length,
    output logic [POS_W-1:0]   head_x,
    output logic [POS_W-1:0]   head_y,
    output logic               busy,
    output logic               scan_done,
    output logic               self_hit,
    output logic               pix_head,
    output logic               pix_body
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int HW    = ((CNT_H_W > POS_W) ? CNT_H_W : POS_W) + 1;
    localparam int VW    = ((CNT_V_W > POS_W) ? CNT_V_W : POS_W) + 1;

    localparam logic [POS_W-1:0] STEP_D  = POS_W'(SQ);
    localparam logic [POS_W-1:0] X_LAST  = POS_W'(X_MAX - SQ);
    localparam logic [POS_W-1:0] Y_LAST  = POS_W'(Y_MAX - SQ);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_INI = LEN_W'(INIT_LEN);

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wrap is decided before the add so the sum never leaves POS_W bits.
    function automatic logic [POS_W-1:0] wrap_inc(input logic [POS_W-1:0] pos,
                                                  input logic [POS_W-1:0] last);
        return (pos >= last) ? '0 : pos + STEP_D;
    endfunction

    function automatic logic [POS_W-1:0] wrap_dec(input logic [POS_W-1:0] pos,
                                                  input logic [POS_W-1:0] last);
        return (pos == '0) ? last : pos - STEP_D;
    endfunction

    logic [POS_W-1:0] seg_x [MAX_LEN];
    logic [POS_W-1:0] seg_y [MAX_LEN];
    logic [LEN_W-1:0] length;
    logic [LEN_W-1:0] k;
    logic [IDX_W-1:0] k_idx;
    logic [1:0]       cur_dir;
    logic [1:0]       next_dir;
    logic [POS_W-1:0] next_x;
    logic [POS_W-1:0] next_y;
    logic             accept;
    logic             hit_k;
    state_t           state;

    logic [HW-1:0]      h_ext;
    logic [VW-1:0]      v_ext;
    logic [MAX_LEN-1:0] match_c;
    logic [MAX_LEN-1:0] match_p1;

    assign snake_length = length;
    assign head_x       = seg_x[0];
    assign head_y       = seg_y[0];
    assign k_idx        = k[IDX_W-1:0];
    assign accept       = step && (state == IDLE);
    assign hit_k        = (seg_x[k_idx] == seg_x[0]) && (seg_y[k_idx] == seg_y[0]);

    // A request for the exact reverse of the current heading is ignored.
    always_comb begin
        next_dir = (dir == (cur_dir ^ 2'b01)) ? cur_dir : dir;
        next_x   = seg_x[0];
        next_y   = seg_y[0];
        case (next_dir)
            DIR_RIGHT: next_x = wrap_inc(seg_x[0], X_LAST);
            DIR_LEFT:  next_x = wrap_dec(seg_x[0], X_LAST);
            DIR_UP:    next_y = wrap_dec(seg_y[0], Y_LAST);
            DIR_DOWN:  next_y = wrap_inc(seg_y[0], Y_LAST);
            default:   next_x = seg_x[0];
        endcase
    end

    always_ff @(posedge clk_25) begin
        if (reset_game) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= POS_W'(INIT_X - i * SQ);
                seg_y[i] <= POS_W'(INIT_Y);
            end
            length    <= LEN_INI;
            cur_dir   <= DIR_RIGHT;
            state     <= IDLE;
            k         <= '0;
            busy      <= 1'b0;
            scan_done <= 1'b0;
            self_hit  <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int i = 1; i < MAX_LEN; i++) begin
                            seg_x[i] <= seg_x[i-1];
                            seg_y[i] <= seg_y[i-1];
                        end
                        seg_x[0] <= next_x;
                        seg_y[0] <= next_y;
                        cur_dir  <= next_dir;
                        if (grow && (length != LEN_MAX))
                            length <= length + 1'b1;
                        k     <= LEN_W'(1);
                        state <= SCAN;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (k >= length) begin
                        state     <= DONE;
                        scan_done <= 1'b1;
                    end else if (hit_k) begin
                        // Jump k to the end so the next scan cycle terminates.
                        self_hit <= 1'b1;
                        k        <= length;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign h_ext = HW'(count_H);
    assign v_ext = VW'(count_V);

    always_comb begin
        match_c = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            match_c[i] = (h_ext >= HW'(seg_x[i])) &&
                         (h_ext <  HW'(seg_x[i]) + HW'(SQ)) &&
                         (v_ext >= VW'(seg_y[i])) &&
                         (v_ext <  VW'(seg_y[i]) + VW'(SQ)) &&
                         (LEN_W'(i) < length);
        end
    end

    // Stage 1: per-segment square match
    always_ff @(posedge clk_25) begin
        if (reset_game)
            match_p1 <= '0;
        else
            match_p1 <= match_c;
    end

    // Stage 2: head / body reduction
    always_ff @(posedge clk_25) begin
        if (reset_game) begin
            pix_head <= 1'b0;
            pix_body <= 1'b0;
        end else begin
            pix_head <= match_p1[0];
            pix_body <= |(match_p1 & ~MAX_LEN'(1));
        end
    end

endmodule

// File: tb/tb_snake_segment_engine.sv
// Directed bench for snake_segment_engine: reset, stepping, wrap, reverse, growth,
// self collision, reset during scan and the pixel pipeline.
module tb_snake_segment_engine;

    logic       clk_25 = 1'b0;
    logic       reset_game = 1'b1;
    logic       step = 1'b0;
    logic [1:0] dir = 2'b00;
    logic       grow = 1'b0;
    logic [9:0] count_H = '0;
    logic [9:0] count_V = '0;
    logic [5:0] snake_length;
    logic [9:0] head_x;
    logic [9:0] head_y;
    logic       busy;
    logic       scan_done;
    logic       self_hit;
    logic       pix_head;
    logic       pix_body;

    int checks = 0;
    int errors = 0;

    snake_segment_engine dut (
        .clk_25(clk_25),
        .reset_game(reset_game),
        .step(step),
        .dir(dir),
        .grow(grow),
        .count_H(count_H),
        .count_V(count_V),
        .snake_length(snake_length),
        .head_x(head_x),
        .head_y(head_y),
        .busy(busy),
        .scan_done(scan_done),
        .self_hit(self_hit),
        .pix_head(pix_head),
        .pix_body(pix_body)
    );

    always #20 clk_25 = ~clk_25;

    task automatic tick();
        @(posedge clk_25);
        #1;
    endtask

    task automatic apply_reset();
        reset_game = 1'b1;
        step = 1'b0;
        grow = 1'b0;
        dir = 2'b00;
        tick();
        tick();
        reset_game = 1'b0;
    endtask

    // Issues one step once idle; n_done is the cycle offset of scan_done, n_hit the first offset self_hit was seen.
    task automatic do_step(input logic [1:0] d, input logic g, output int n_done, output int n_hit);
        int guard = 0;
        while (busy && guard < 200) begin
            tick();
            guard++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_wait: busy=%b after %0d cycles, required 0", busy, guard);
        end
        step = 1'b1;
        dir = d;
        grow = g;
        tick();
        step = 1'b0;
        grow = 1'b0;
        n_done = 0;
        n_hit = 0;
        for (int n = 1; n < 200; n++) begin
            if (self_hit && n_hit == 0) n_hit = n;
            if (scan_done) begin
                n_done = n;
                break;
            end
            tick();
        end
        checks++;
        if (n_done == 0) begin
            errors++;
            $display("FAIL scan_timeout: scan_done never seen, required within 200 cycles");
        end
        tick();
    endtask

    task automatic test_reset();
        reset_game = 1'b1;
        count_H = 10'd325;
        count_V = 10'd245;
        repeat (3) tick();
        checks++;
        if (snake_length !== 6'd3 || head_x !== 10'd320 || head_y !== 10'd240) begin
            errors++;
            $display("FAIL reset_pos: len=%0d head=(%0d,%0d), required len=3 head=(320,240)", snake_length, head_x, head_y);
        end
        checks++;
        if (busy !== 1'b0 || self_hit !== 1'b0 || scan_done !== 1'b0 || pix_head !== 1'b0 || pix_body !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b hit=%b done=%b ph=%b pb=%b, required all 0", busy, self_hit, scan_done, pix_head, pix_body);
        end
        reset_game = 1'b0;
        tick();
        tick();
        checks++;
        if (pix_head !== 1'b1 || pix_body !== 1'b0) begin
            errors++;
            $display("FAIL reset_draw_head: ph=%b pb=%b at x=325, required ph=1 pb=0", pix_head, pix_body);
        end
        count_H = 10'd315;
        tick();
        tick();
        checks++;
        if (pix_head !== 1'b0 || pix_body !== 1'b1) begin
            errors++;
            $display("FAIL reset_draw_seg1: ph=%b pb=%b at x=315, required ph=0 pb=1", pix_head, pix_body);
        end
        count_H = 10'd305;
        tick();
        tick();
        checks++;
        if (pix_head !== 1'b0 || pix_body !== 1'b1) begin
            errors++;
            $display("FAIL reset_draw_seg2: ph=%b pb=%b at x=305, required ph=0 pb=1", pix_head, pix_body);
        end
        count_H = 10'd295;
        tick();
        tick();
        checks++;
        if (pix_head !== 1'b0 || pix_body !== 1'b0) begin
            errors++;
            $display("FAIL reset_inactive_seg3: ph=%b pb=%b at x=295, required 0 0", pix_head, pix_body);
        end
    endtask

    task automatic test_step();
        step = 1'b1;
        dir = 2'b00;
        grow = 1'b0;
        tick();
        checks++;
        if (head_x !== 10'd330 || head_y !== 10'd240 || busy !== 1'b1) begin
            errors++;
            $display("FAIL step_move: head=(%0d,%0d) busy=%b, required (330,240) busy=1", head_x, head_y, busy);
        end
        // Step request while busy, asking for up and growth; must be dropped.
        dir = 2'b10;
        grow = 1'b1;
        tick();
        step = 1'b0;
        grow = 1'b0;
        dir = 2'b00;
        checks++;
        if (head_x !== 10'd330 || head_y !== 10'd240 || snake_length !== 6'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL step_dropped: head=(%0d,%0d) len=%0d busy=%b, required (330,240) len=3 busy=1", head_x, head_y, snake_length, busy);
        end
        tick();
        checks++;
        if (scan_done !== 1'b0) begin
            errors++;
            $display("FAIL step_done_early: scan_done=%b at c+3, required 0", scan_done);
        end
        tick();
        checks++;
        if (scan_done !== 1'b1 || self_hit !== 1'b0) begin
            errors++;
            $display("FAIL step_done: scan_done=%b hit=%b at c+4, required 1 0", scan_done, self_hit);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || scan_done !== 1'b0) begin
            errors++;
            $display("FAIL step_idle: busy=%b done=%b at c+5, required 0 0", busy, scan_done);
        end
    endtask

    task automatic test_pixel_lag();
        count_H = 10'd0;
        count_V = 10'd0;
        repeat (3) tick();
        count_H = 10'd330;
        count_V = 10'd245;
        tick();
        checks++;
        if (pix_head !== 1'b0) begin
            errors++;
            $display("FAIL pix_lag1: pix_head=%b one cycle after, required 0", pix_head);
        end
        tick();
        checks++;
        if (pix_head !== 1'b1 || pix_body !== 1'b0) begin
            errors++;
            $display("FAIL pix_lag2: ph=%b pb=%b two cycles after, required 1 0", pix_head, pix_body);
        end
    endtask

    task automatic test_reverse();
        int nd;
        int nh;
        do_step(2'b01, 1'b0, nd, nh);
        checks++;
        if (head_x !== 10'd340 || head_y !== 10'd240) begin
            errors++;
            $display("FAIL reverse_ignored: head=(%0d,%0d), required (340,240)", head_x, head_y);
        end
    endtask

    task automatic test_wrap();
        int nd;
        int nh;
        int steps = 0;
        while (head_x != 10'd630 && steps < 100) begin
            do_step(2'b00, 1'b0, nd, nh);
            steps++;
        end
        checks++;
        if (steps != 29) begin
            errors++;
            $display("FAIL wrap_reach_630: took %0d steps, required 29", steps);
        end
        do_step(2'b00, 1'b0, nd, nh);
        checks++;
        if (head_x !== 10'd0 || head_y !== 10'd240) begin
            errors++;
            $display("FAIL wrap_right: head=(%0d,%0d), required (0,240)", head_x, head_y);
        end
        steps = 0;
        while (head_y != 10'd0 && steps < 100) begin
            do_step(2'b10, 1'b0, nd, nh);
            steps++;
        end
        checks++;
        if (steps != 24 || head_x !== 10'd0) begin
            errors++;
            $display("FAIL wrap_reach_top: %0d steps x=%0d, required 24 steps x=0", steps, head_x);
        end
        do_step(2'b10, 1'b0, nd, nh);
        checks++;
        if (head_y !== 10'd470 || head_x !== 10'd0) begin
            errors++;
            $display("FAIL wrap_up: head=(%0d,%0d), required (0,470)", head_x, head_y);
        end
        do_step(2'b11, 1'b0, nd, nh);
        checks++;
        if (head_y !== 10'd460 || self_hit !== 1'b0) begin
            errors++;
            $display("FAIL wrap_reverse_down: y=%0d hit=%b, required 460 0", head_y, self_hit);
        end
    endtask

    task automatic test_grow();
        int nd;
        int nh;
        int bad = 0;
        apply_reset();
        do_step(2'b00, 1'b1, nd, nh);
        checks++;
        if (snake_length !== 6'd4 || nd != 5) begin
            errors++;
            $display("FAIL grow_first: len=%0d done_at=c+%0d, required len=4 c+5", snake_length, nd);
        end
        for (int i = 2; i <= 29; i++) begin
            do_step(2'b00, 1'b1, nd, nh);
            checks++;
            if (snake_length !== 6'(3 + i) || head_x !== 10'(320 + 10 * i)) begin
                errors++;
                $display("FAIL grow_step%0d: len=%0d x=%0d, required len=%0d x=%0d", i, snake_length, head_x, 3 + i, 320 + 10 * i);
            end
        end
        for (int i = 0; i < 2; i++) begin
            do_step(2'b00, 1'b1, nd, nh);
            checks++;
            if (snake_length !== 6'd32 || head_x !== 10'(620 + 10 * i)) begin
                errors++;
                $display("FAIL grow_saturate%0d: len=%0d x=%0d, required len=32 x=%0d", i, snake_length, head_x, 620 + 10 * i);
            end
        end
        checks++;
        if (nd != 33 || self_hit !== 1'b0) begin
            errors++;
            $display("FAIL grow_full_scan: done_at=c+%0d hit=%b, required c+33 hit=0", nd, self_hit);
        end
        if (bad != 0) errors++;
    endtask

    task automatic test_self_hit();
        int nd;
        int nh;
        apply_reset();
        do_step(2'b00, 1'b1, nd, nh);
        do_step(2'b00, 1'b1, nd, nh);
        checks++;
        if (snake_length !== 6'd5 || head_x !== 10'd340) begin
            errors++;
            $display("FAIL hit_setup: len=%0d x=%0d, required 5 340", snake_length, head_x);
        end
        do_step(2'b11, 1'b0, nd, nh);
        do_step(2'b01, 1'b0, nd, nh);
        checks++;
        if (self_hit !== 1'b0 || head_x !== 10'd330 || head_y !== 10'd250) begin
            errors++;
            $display("FAIL hit_before: hit=%b head=(%0d,%0d), required 0 (330,250)", self_hit, head_x, head_y);
        end
        do_step(2'b10, 1'b0, nd, nh);
        checks++;
        if (head_x !== 10'd330 || head_y !== 10'd240 || self_hit !== 1'b1) begin
            errors++;
            $display("FAIL hit_flag: head=(%0d,%0d) hit=%b, required (330,240) 1", head_x, head_y, self_hit);
        end
        checks++;
        if (nh != 5 || nd != 6) begin
            errors++;
            $display("FAIL hit_timing: hit_at=c+%0d done_at=c+%0d, required c+5 c+6", nh, nd);
        end
        do_step(2'b10, 1'b0, nd, nh);
        checks++;
        if (head_y !== 10'd230 || self_hit !== 1'b1) begin
            errors++;
            $display("FAIL hit_sticky: y=%0d hit=%b, required 230 1", head_y, self_hit);
        end
        // Reset while a scan is in flight.
        step = 1'b1;
        dir = 2'b00;
        tick();
        step = 1'b0;
        reset_game = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midscan_busy: busy=%b, required 1", busy);
        end
        tick();
        reset_game = 1'b0;
        checks++;
        if (busy !== 1'b0 || scan_done !== 1'b0 || self_hit !== 1'b0 || snake_length !== 6'd3 || head_x !== 10'd320 || head_y !== 10'd240) begin
            errors++;
            $display("FAIL midscan_reset: busy=%b done=%b hit=%b len=%0d head=(%0d,%0d), required 0 0 0 3 (320,240)", busy, scan_done, self_hit, snake_length, head_x, head_y);
        end
        repeat (3) begin
            tick();
            checks++;
            if (scan_done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midscan_quiet: done=%b busy=%b, required 0 0", scan_done, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_pixel_lag();
        test_reverse();
        test_wrap();
        test_grow();
        test_self_hit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
